mem_responder: RTL

- Memory-side responder for the core's MAR/MDR fetch and load/store path.
- Accepts one word request at a time from the control/datapath side.
- Holds a word-addressed storage array and inserts a programmable number of wait states.
- Returns a single-cycle response pulse on rsp_valid, which drives the core's mdr_valid.

---
 rtl/mem_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory responder with programmable wait states.
// Accepts one request at a time, inserts LATENCY wait cycles, then pulses rsp_valid.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (flags out-of-range / misaligned addresses).
module mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_err;
    logic               rsp_err_q;
    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  word_full;
    logic [IDX_W-1:0]   req_idx;
    logic               flag;
    logic               accept;

    logic               sel_we;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_err;
    logic [31:0]        rdata_next;

    assign word_full = {2'b00, req_addr[ADDR_W-1:2]};
    assign req_idx   = IDX_W'(word_full % ADDR_W'(DEPTH));
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

`ifdef MEM_BOUNDS_CHECK_EN
    assign flag    = (word_full >= ADDR_W'(DEPTH)) || (req_addr[1:0] != 2'b00);
    assign rsp_err = rsp_err_q;
`else
    logic unused_bits;
    assign flag        = 1'b0;
    assign rsp_err     = 1'b0;
    assign unused_bits = rsp_err_q ^ (^req_addr[1:0]);
`endif

    // Response data source: live request when LATENCY=0 (IDLE->RESP), latched request otherwise.
    always_comb begin
        sel_we  = lat_we;
        sel_idx = lat_idx;
        sel_err = lat_err;
        if (state == IDLE) begin
            sel_we  = req_we;
            sel_idx = req_idx;
            sel_err = flag;
        end
        rdata_next = '0;
        if (sel_err) begin
            rdata_next = 32'hDEAD_BEEF;
        end else if (!sel_we) begin
            rdata_next = mem[sel_idx];
        end
    end

    // Storage: byte-lane writes committed at the accept edge; never reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !flag) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_err   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        lat_we  <= req_we;
                        lat_idx <= req_idx;
                        lat_err <= flag;
                        if (LATENCY > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rdata_next;
                            rsp_err_q <= sel_err;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_next;
                        rsp_err_q <= sel_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
